// File: rtl/verlet_frame_scheduler_if.sv
// Handshake/bus bundle between the frame scheduler and the cloth core datapath.
// MOUSE_GRAB_EN adds the mouse-grab inputs and the override output.
interface verlet_frame_scheduler_if #(
  parameter int unsigned addr_width = 8
) ();
  logic                  frame_tick;
  logic                  stall;
  logic                  readout_ready;
  logic                  overrun_clr;
  logic [addr_width-1:0] node_addr;
  logic                  verlet_en;
  logic                  constraint_en;
  logic                  ram_we;
  logic                  readout_valid;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;
`ifdef MOUSE_GRAB_EN
  logic                  grab_active;
  logic [addr_width-1:0] grab_node;
  logic                  mouse_override;
`endif

  // Scheduler side
  modport master (
`ifdef MOUSE_GRAB_EN
    input  grab_active, grab_node,
    output mouse_override,
`endif
    input  frame_tick, stall, readout_ready, overrun_clr,
    output node_addr, verlet_en, constraint_en, ram_we,
    output readout_valid, busy, frame_done, overrun
  );

  // Datapath / control side
  modport slave (
`ifdef MOUSE_GRAB_EN
    output grab_active, grab_node,
    input  mouse_override,
`endif
    output frame_tick, stall, readout_ready, overrun_clr,
    input  node_addr, verlet_en, constraint_en, ram_we,
    input  readout_valid, busy, frame_done, overrun
  );
endinterface

// File: rtl/verlet_frame_scheduler.sv
// Per-frame sequencer for one cloth core: Verlet pass, constraint passes, readout.
// Optional MOUSE_GRAB_EN macro enables the grabbed-node override.
module verlet_frame_scheduler #(
  parameter int unsigned node_contains    = 5,
  parameter int unsigned constraint_iters = 3,
  parameter int unsigned addr_width       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  verlet_frame_scheduler_if.master bus
);

  localparam int unsigned ITER_W = (constraint_iters > 1) ? $clog2(constraint_iters) : 1;
  localparam logic [addr_width-1:0] LAST_NODE = addr_width'(node_contains - 1);
  localparam logic [addr_width-1:0] LAST_LINK =
    addr_width'((node_contains > 1) ? (node_contains - 2) : 0);
  localparam logic [ITER_W-1:0] LAST_ITER =
    ITER_W'((constraint_iters > 0) ? (constraint_iters - 1) : 0);
  localparam bit SKIP_CONSTRAIN = (node_contains == 1) || (constraint_iters == 0);

  typedef enum logic [2:0] {IDLE, VERLET, CONSTRAIN, READOUT, DONE} state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  verlet_q, verlet_d;
  logic                  constr_q, constr_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
`ifdef MOUSE_GRAB_EN
  logic                  override_q, override_d;
`endif

  // Next-state and next-output logic; outputs describe the upcoming cycle
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iter_d    = iter_q;
    verlet_d  = 1'b0;
    constr_d  = 1'b0;
    we_d      = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;
`ifdef MOUSE_GRAB_EN
    override_d = 1'b0;
`endif

    // A tick while a frame is in flight is dropped; set beats clear
    if (bus.overrun_clr)
      overrun_d = 1'b0;
    if (bus.frame_tick && (state_q != IDLE))
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          state_d  = VERLET;
          addr_d   = '0;
          iter_d   = '0;
          verlet_d = 1'b1;
          we_d     = 1'b1;
        end
      end
      VERLET: begin
        if (!bus.stall) begin
          if (addr_q == LAST_NODE) begin
            addr_d = '0;
            iter_d = '0;
            if (SKIP_CONSTRAIN) begin
              state_d = READOUT;
              valid_d = 1'b1;
            end else begin
              state_d  = CONSTRAIN;
              constr_d = 1'b1;
              we_d     = 1'b1;
            end
          end else begin
            addr_d   = addr_q + addr_width'(1);
            verlet_d = 1'b1;
            we_d     = 1'b1;
          end
        end
      end
      CONSTRAIN: begin
        if (!bus.stall) begin
          if (addr_q == LAST_LINK) begin
            addr_d = '0;
            if (iter_q == LAST_ITER) begin
              state_d = READOUT;
              valid_d = 1'b1;
            end else begin
              iter_d   = iter_q + ITER_W'(1);
              constr_d = 1'b1;
              we_d     = 1'b1;
            end
          end else begin
            addr_d   = addr_q + addr_width'(1);
            constr_d = 1'b1;
            we_d     = 1'b1;
          end
        end
      end
      READOUT: begin
        valid_d = 1'b1;
        if (valid_q && bus.readout_ready) begin
          if (addr_q == LAST_NODE) begin
            state_d = DONE;
            addr_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + addr_width'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        iter_d  = '0;
      end
    endcase

`ifdef MOUSE_GRAB_EN
    // Grabbed node takes the mouse position; its links keep that end pinned
    if (verlet_d && bus.grab_active && (addr_d == bus.grab_node)) begin
      verlet_d   = 1'b0;
      override_d = 1'b1;
    end
    if (constr_d && bus.grab_active &&
        ((addr_d == bus.grab_node) || (addr_width'(addr_d + addr_width'(1)) == bus.grab_node)))
      override_d = 1'b1;
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      iter_q    <= '0;
      verlet_q  <= 1'b0;
      constr_q  <= 1'b0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MOUSE_GRAB_EN
      override_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iter_q    <= iter_d;
      verlet_q  <= verlet_d;
      constr_q  <= constr_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef MOUSE_GRAB_EN
      override_q <= override_d;
`endif
    end
  end

  assign bus.node_addr     = addr_q;
  assign bus.verlet_en     = verlet_q;
  assign bus.constraint_en = constr_q;
  assign bus.ram_we        = we_q;
  assign bus.readout_valid = valid_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.overrun       = overrun_q;
`ifdef MOUSE_GRAB_EN
  assign bus.mouse_override = override_q;
`endif

endmodule

// File: tb/tb_verlet_frame_scheduler.sv
// Scoreboard bench for verlet_frame_scheduler: per-cycle expected output records
// are queued when a frame is launched and compared as the DUT steps through it.
module tb_verlet_frame_scheduler;
  localparam int unsigned AW = 8;

  // Flag order: verlet_en, constraint_en, ram_we, readout_valid, busy, frame_done
  localparam logic [5:0] F_V = 6'b101010;
  localparam logic [5:0] F_S = 6'b000010;
  localparam logic [5:0] F_C = 6'b011010;
  localparam logic [5:0] F_R = 6'b000110;
  localparam logic [5:0] F_D = 6'b000011;
  localparam logic [5:0] F_I = 6'b000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  verlet_frame_scheduler_if #(.addr_width(AW)) bus ();
  verlet_frame_scheduler_if #(.addr_width(AW)) bus1 ();

  verlet_frame_scheduler #(.node_contains(5), .constraint_iters(3), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  verlet_frame_scheduler #(.node_contains(1), .constraint_iters(3), .addr_width(AW)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  bit seen_c1 = 1'b0;

  always @(posedge clk) if (bus1.constraint_en === 1'b1) seen_c1 <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit 15 marks node_addr as don't-care for that cycle
  function automatic logic [15:0] rec(input logic dc, input logic [7:0] a, input logic [5:0] f);
    return {dc, 1'b0, a, f};
  endfunction

  function automatic logic [15:0] obs0();
    return {2'b00, bus.node_addr, bus.verlet_en, bus.constraint_en, bus.ram_we,
            bus.readout_valid, bus.busy, bus.frame_done};
  endfunction

  function automatic logic [15:0] obs1();
    return {2'b00, bus1.node_addr, bus1.verlet_en, bus1.constraint_en, bus1.ram_we,
            bus1.readout_valid, bus1.busy, bus1.frame_done};
  endfunction

  task automatic cmp_rec(input string tag, input logic [15:0] o_in, input logic [15:0] e_in);
    logic [15:0] o, e;
    o = o_in;
    e = e_in;
    if (e[15]) begin
      o[13:6] = '0;
      e[13:6] = '0;
    end
    e[15] = 1'b0;
    check(tag, 32'(o), 32'(e));
  endtask

  // Advance one cycle and score whatever the scoreboards expect for it
  task automatic step(input string tag, input int c);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) cmp_rec($sformatf("%s_c%0d", tag, c), obs0(), exp_q.pop_front());
    if (exp1_q.size() > 0) cmp_rec($sformatf("%s1_c%0d", tag, c), obs1(), exp1_q.pop_front());
  endtask

  task automatic push_verlet_and_constrain();
    for (int a = 0; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_V));
    for (int it = 0; it < 3; it++)
      for (int l = 0; l < 4; l++) exp_q.push_back(rec(1'b0, 8'(l), F_C));
  endtask

  task automatic push_std_frame();
    push_verlet_and_constrain();
    for (int a = 0; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_R));
    exp_q.push_back(rec(1'b1, 8'd0, F_D));
    exp_q.push_back(rec(1'b1, 8'd0, F_I));
  endtask

  task automatic idle_inputs();
    bus.frame_tick = 1'b0;
    bus.stall = 1'b0;
    bus.readout_ready = 1'b1;
    bus.overrun_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus1.frame_tick = 1'b0;
    bus1.stall = 1'b0;
    bus1.readout_ready = 1'b1;
    bus1.overrun_clr = 1'b0;
`ifdef MOUSE_GRAB_EN
    bus.grab_active = 1'b0;
    bus.grab_node = '0;
    bus1.grab_active = 1'b0;
    bus1.grab_node = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({obs0(), bus.overrun}), 32'({rec(1'b0, 8'd0, F_I), 1'b0}));
    reset = 1'b0;
    for (int c = 0; c < 2; c++) step("settle", c);

    // Plain frame: done at cycle 23, idle at 24
    for (int c = 0; c < 26; c++) begin
      step("basic", c);
      bus.frame_tick = (c == 0);
      if (c == 0) push_std_frame();
    end
    check("basic_drain", 32'(exp_q.size()), 32'd0);

    // Stall held three cycles at node 2
    for (int c = 0; c < 29; c++) begin
      step("stall", c);
      bus.frame_tick = (c == 0);
      bus.stall = (c >= 3) && (c <= 5);
      if (c == 0) begin
        for (int a = 0; a < 3; a++) exp_q.push_back(rec(1'b0, 8'(a), F_V));
        repeat (3) exp_q.push_back(rec(1'b0, 8'd2, F_S));
        for (int a = 3; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_V));
        for (int it = 0; it < 3; it++)
          for (int l = 0; l < 4; l++) exp_q.push_back(rec(1'b0, 8'(l), F_C));
        for (int a = 0; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_R));
        exp_q.push_back(rec(1'b1, 8'd0, F_D));
        exp_q.push_back(rec(1'b1, 8'd0, F_I));
      end
    end
    idle_inputs();
    check("stall_drain", 32'(exp_q.size()), 32'd0);

    // Readout backpressure: ready 1,0,0,1 from cycle 18
    for (int c = 0; c < 28; c++) begin
      step("ready", c);
      bus.frame_tick = (c == 0);
      bus.readout_ready = !((c == 19) || (c == 20));
      if (c == 0) begin
        push_verlet_and_constrain();
        exp_q.push_back(rec(1'b0, 8'd0, F_R));
        repeat (3) exp_q.push_back(rec(1'b0, 8'd1, F_R));
        for (int a = 2; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_R));
        exp_q.push_back(rec(1'b1, 8'd0, F_D));
        exp_q.push_back(rec(1'b1, 8'd0, F_I));
      end
    end
    idle_inputs();
    check("ready_drain", 32'(exp_q.size()), 32'd0);

    // Overrun set/clear, including tick and clear together
    for (int c = 0; c < 60; c++) begin
      step("ovr", c);
      if (c == 1)  check("ovr_start_tick", 32'(bus.overrun), 32'd0);
      if (c == 10) check("ovr_before", 32'(bus.overrun), 32'd0);
      if (c == 11) check("ovr_set", 32'(bus.overrun), 32'd1);
      if (c == 23) check("ovr_sticky", 32'(bus.overrun), 32'd1);
      if (c == 31) check("ovr_clr", 32'(bus.overrun), 32'd0);
      if (c == 36) check("ovr_set_wins", 32'(bus.overrun), 32'd1);
      if (c == 41) check("ovr_clr2", 32'(bus.overrun), 32'd0);
      bus.frame_tick = (c == 0) || (c == 10) || (c == 32) || (c == 35);
      bus.overrun_clr = (c == 30) || (c == 35) || (c == 40);
      if ((c == 0) || (c == 32)) push_std_frame();
    end
    idle_inputs();
    check("ovr_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame in CONSTRAIN, then a fresh frame
    for (int c = 0; c < 9; c++) begin
      step("rst", c);
      bus.frame_tick = (c == 0);
      if (c == 0) begin
        for (int a = 0; a < 5; a++) exp_q.push_back(rec(1'b0, 8'(a), F_V));
        exp_q.push_back(rec(1'b0, 8'd0, F_C));
        exp_q.push_back(rec(1'b0, 8'd1, F_C));
      end
    end
    check("rst_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async", 32'({obs0(), bus.overrun}), 32'd0);
    step("rst_hold", 0);
    reset = 1'b0;
    for (int c = 0; c < 26; c++) begin
      step("restart", c);
      bus.frame_tick = (c == 0);
      if (c == 0) push_std_frame();
    end
    idle_inputs();
    check("restart_drain", 32'(exp_q.size()), 32'd0);

    // Single-node core: no constraint pass, done at cycle 3
    for (int c = 0; c < 7; c++) begin
      step("single", c);
      bus1.frame_tick = (c == 0);
      if (c == 0) begin
        exp1_q.push_back(rec(1'b0, 8'd0, F_V));
        exp1_q.push_back(rec(1'b0, 8'd0, F_R));
        exp1_q.push_back(rec(1'b1, 8'd0, F_D));
        exp1_q.push_back(rec(1'b1, 8'd0, F_I));
      end
    end
    check("single_drain", 32'(exp1_q.size()), 32'd0);
    check("single_no_constrain", 32'(seen_c1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/verlet_frame_scheduler.md
Name: verlet_frame_scheduler

Overview:
Per-frame sequencer for one cloth-simulation core. On each frame tick it runs three passes over the node RAM in order: a Verlet integration pass over every node, a fixed number of distance-constraint passes over adjacent node links, and a valid/ready readout pass to the display/aggregation side. It drives the RAM address and write enable that the core datapath consumes, and reports done and overrun status.

Parameters:
node_contains, 5, nodes held by the core (>=1)
constraint_iters, 3, constraint passes per frame (>=0)
addr_width, 8, width of node/link address (2^addr_width >= node_contains)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
frame_tick  in  1  single-cycle pulse requesting a new frame
stall  in  1  freezes VERLET/CONSTRAIN progress while high
readout_ready  in  1  consumer accepts current readout beat
overrun_clr  in  1  clears overrun flag
node_addr  out  addr_width  node index (VERLET/READOUT) or link index (CONSTRAIN)
verlet_en  out  1  datapath performs Verlet update of node_addr
constraint_en  out  1  datapath relaxes link node_addr <-> node_addr+1
ram_we  out  1  write result back to RAM at node_addr
readout_valid  out  1  node_addr carries a readout beat
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at frame end
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset (async, high): state IDLE; node_addr=0, iter count=0; all outputs 0.
- All outputs registered; they reflect the current state and counters.
- IDLE: frame_tick sampled high -> VERLET with node_addr=0 on the next cycle (latency 1).
- VERLET: verlet_en=ram_we=1 each non-stalled cycle; node_addr +1 per cycle. After node_contains-1 -> CONSTRAIN, node_addr=0, iter=0. If node_contains==1 or constraint_iters==0, go to READOUT instead.
- CONSTRAIN: constraint_en=ram_we=1; link index 0..node_contains-2, +1 per non-stalled cycle. After the last link: if iter==constraint_iters-1 -> READOUT, node_addr=0; else iter+1, node_addr=0.
- stall high in VERLET/CONSTRAIN: verlet_en, constraint_en and ram_we forced 0; node_addr and iter hold. stall has no effect in other states.
- READOUT: readout_valid=1; node_addr stable until readout_valid&&readout_ready, then +1. Accept of node node_contains-1 -> DONE. Valid never drops before it is accepted.
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- Frame length (no stall, ready high): node_contains + constraint_iters*(node_contains-1) + node_contains + 1 cycles; 23 for the defaults.
- frame_tick in any state except IDLE: ignored (no restart); overrun set. Also ignored on the IDLE cycle after DONE only if it is not sampled in IDLE (no queuing).
- overrun_clr and a new overrun in the same cycle: set wins.
- Counters never exceed node_contains-1; no wrap-around.
- Reset mid-frame aborts immediately. Partial RAM writes stay. Outputs go to 0 asynchronously.

Optional Feature:
MOUSE_GRAB_EN: adds inputs grab_active (1) and grab_node (addr_width), and output mouse_override (1). During VERLET, when grab_active && node_addr==grab_node: verlet_en=0, mouse_override=1, ram_we=1, so the datapath writes the mouse position instead. In CONSTRAIN, when grab_active and link node_addr touches grab_node (node_addr==grab_node or node_addr+1==grab_node), mouse_override=1 (the grabbed end is held fixed). Without the macro these ports are absent and the behaviour is exactly as above.

Test Plan:
- Default params, readout_ready=1, frame_tick at cycle 0 -> VERLET addr 0..4 on cycles 1-5, CONSTRAIN links 0..3 x3 on cycles 6-17, readout 0..4 on cycles 18-22, frame_done at 23, busy low at 24.
- stall high for 3 cycles while at VERLET node_addr=2 -> addr holds 2 and verlet_en/ram_we are 0 for 3 cycles; frame_done is delayed by 3 cycles (cycle 26).
- readout_ready toggling 1,0,0,1 from cycle 18 -> node_addr 0 accepted, then addr 1 held with valid for 2 cycles, accepted on the 4th cycle.
- frame_tick pulsed at cycle 10 mid-frame -> overrun=1, frame still ends at 23. overrun_clr at 30 -> overrun=0. Tick and clr in the same cycle while busy -> overrun stays 1.
- reset asserted at cycle 8 (CONSTRAIN) -> all outputs 0 and busy=0 in the same cycle; frame_tick after reset release starts a fresh frame at addr 0.
- node_contains=1, constraint_iters=3 -> VERLET 1 cycle, no constraint_en ever, 1 readout beat, frame_done at cycle 3.
